// File: rtl/i2c_target_regif.sv
// I2C register target: 7-bit address, 16-bit register pointer (MSB first), then data bytes.
// Writes become wr_en pulses and reads become rd_req fetches; the pointer auto-increments.
module i2c_target_regif #(
  parameter logic [6:0] OWN_ADDR    = 7'h29,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        start_det,
  output logic        stop_det
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, REG_H, ACK_H, REG_L, ACK_L, WDATA, ACK_W, RDATA, MACK, IGNORE
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic        scl_q, sda_q;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  reg_h;
  logic [15:0] pointer;
  logic        rw;
  logic        ack_on;
  logic        rd_pend;
  logic        sda_oe_r;

  // Line synchronizers and edge detection; idle bus level is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_sync[SYNC_STAGES-1];
      sda_q    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic scl, sda;
  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];

  logic start_c, stop_c, scl_rise, scl_fall;
  assign start_c  = scl & scl_q & sda_q & ~sda;
  assign stop_c   = scl & scl_q & ~sda_q & sda;
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;

  logic       is_rx, is_ack, byte_done, ack_begin, ack_end, mack_rise, tx_fall;
  logic [7:0] rx_byte;
  assign is_rx     = state inside {ADDR, REG_H, REG_L, WDATA};
  assign is_ack    = state inside {ACK_A, ACK_H, ACK_L, ACK_W};
  assign rx_byte   = {shreg[6:0], sda};
  assign byte_done = is_rx & scl_rise & (bit_cnt == 3'd0);
  // ack_on marks the second half of an ACK slot (our ACK driven, or master ACK seen).
  assign ack_begin = is_ack & scl_fall & ~ack_on;
  assign ack_end   = (is_ack | (state == MACK)) & scl_fall & ack_on;
  assign mack_rise = (state == MACK) & scl_rise;
  assign tx_fall   = (state == RDATA) & scl_fall;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (stop_c) begin
      next_state = IDLE;
    end else if (start_c) begin
      next_state = ADDR;
    end else begin
      case (state)
        ADDR:    if (byte_done) next_state = (rx_byte[7:1] == OWN_ADDR) ? ACK_A : IGNORE;
        REG_H:   if (byte_done) next_state = ACK_H;
        REG_L:   if (byte_done) next_state = ACK_L;
        WDATA:   if (byte_done) next_state = ACK_W;
        ACK_A:   if (ack_end)   next_state = rw ? RDATA : REG_H;
        ACK_H:   if (ack_end)   next_state = REG_L;
        ACK_L:   if (ack_end)   next_state = WDATA;
        ACK_W:   if (ack_end)   next_state = WDATA;
        RDATA:   if (tx_fall && bit_cnt == 3'd0) next_state = MACK;
        MACK: begin
          if (mack_rise && sda) next_state = IGNORE;
          else if (ack_end)     next_state = RDATA;
        end
        default: next_state = state;
      endcase
    end
  end

  logic shift_en, addr_hit, addr_done, hdr_load, ptr_load, wr_fire, rd_fire, mack_ack;
  logic oe_load, oe_val;

  always_comb begin
    // NOTE: every control gets a default before any condition so none of them can become a latch.
    shift_en  = is_rx & scl_rise;
    addr_done = (state == ADDR) & byte_done;
    addr_hit  = addr_done & (rx_byte[7:1] == OWN_ADDR);
    hdr_load  = (state == REG_H) & byte_done;
    ptr_load  = (state == REG_L) & byte_done;
    wr_fire   = (state == WDATA) & byte_done;
    mack_ack  = mack_rise & ~sda;
    rd_fire   = ((state == ACK_A) & rw & ack_on & scl_rise) | mack_ack;
    oe_load   = 1'b0;
    oe_val    = 1'b0;
    if (start_c || stop_c) begin
      oe_load = 1'b1;
    end else if (ack_begin) begin
      oe_load = 1'b1;
      oe_val  = 1'b1;
    end else if (ack_end) begin
      oe_load = 1'b1;
      oe_val  = (((state == ACK_A) && rw) || (state == MACK)) ? ~shreg[7] : 1'b0;
    end else if (tx_fall) begin
      oe_load = 1'b1;
      oe_val  = (bit_cnt == 3'd0) ? 1'b0 : ~shreg[6];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later statements win on overlap.
  always_ff @(posedge clock) begin
    if (reset) begin
      sda_oe_r  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bit_cnt   <= 3'd7;
      shreg     <= '0;
      reg_h     <= '0;
      pointer   <= '0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      start_det <= start_c;
      stop_det  <= stop_c;
      wr_en     <= 1'b0;
      rd_req    <= 1'b0;
      rd_pend   <= rd_req;
      if (oe_load) sda_oe_r <= oe_val;
      if (start_c) begin
        bit_cnt <= 3'd7;
        ack_on  <= 1'b0;
      end
      if (stop_c) begin
        busy   <= 1'b0;
        ack_on <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= rx_byte;
        bit_cnt <= bit_cnt - 3'd1;
      end
      if (addr_done) rw <= sda;
      if (addr_hit)  busy <= 1'b1;
      if (hdr_load)  reg_h <= rx_byte;
      if (ptr_load)  pointer <= {reg_h, rx_byte};
      if (wr_fire) begin
        wr_en   <= 1'b1;
        wr_addr <= pointer;
        wr_data <= rx_byte;
      end
      if (wr_en) pointer <= pointer + 16'd1;
      if (ack_begin) ack_on <= 1'b1;
      if (ack_end) begin
        ack_on  <= 1'b0;
        bit_cnt <= 3'd7;
      end
      if (rd_fire) begin
        rd_req  <= 1'b1;
        rd_addr <= mack_ack ? pointer + 16'd1 : pointer;
      end
      if (mack_ack) begin
        pointer <= pointer + 16'd1;
        ack_on  <= 1'b1;
      end
      if (tx_fall) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt - 3'd1;
      end
      // Fetched byte arrives the cycle after rd_req.
      if (rd_pend) shreg <= rd_data;
    end
  end

  // Release SDA combinationally while reset is held.
  assign sda_oe = sda_oe_r & ~reset;

endmodule
